serial_deser: RTL and testbench
===============================

Name: serial_deser

Overview:
Serial receiver that pairs with the team's parallel-load/shift register used as a transmitter. It accepts a framed bitstream on one serial line and rebuilds the parallel word. It supports MSB-first (left-shift) and LSB-first (right-shift) bit order. It presents each completed word through a one-entry valid/ready output buffer and reports sticky overrun and framing errors.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 2..16)

Ports:
clk  input  1  system clock
nrst  input  1  synchronous active-low reset
en  input  1  bit strobe; sdata is sampled only on cycles where en=1
sdata  input  1  serial line; idles high
msb_first  input  1  1: first data bit is the MSB; 0: first data bit is the LSB
ready_i  input  1  consumer accepts data_o when valid_o=1
clr_i  input  1  clears overrun_o and frame_err_o
data_o  output  WIDTH  received word
valid_o  output  1  data_o holds an unconsumed word
busy_o  output  1  frame reception in progress (state != IDLE)
overrun_o  output  1  sticky: a good frame was dropped because the buffer was full
frame_err_o  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (nrst=0 at a clk edge): state=IDLE, shift register=0, bit counter=0, data_o=0, valid_o=0, overrun_o=0, frame_err_o=0; busy_o=0.
- Frame format on the en-qualified samples: start bit (0), then WIDTH data bits, then stop bit (1).
- Cycles with en=0 change nothing except handshake and clear effects.
- IDLE state:
  - en=1 and sdata=0 -> DATA; counter=0; latch msb_first into an internal order bit.
  - sdata=1 -> stay in IDLE.
  - msb_first changes after the start bit are ignored until the next frame.
- DATA state, each en=1:
  - MSB-first: shreg <= {shreg[WIDTH-2:0], sdata}.
  - LSB-first: shreg <= {sdata, shreg[WIDTH-1:1]}.
  - counter increments. On the sample where counter==WIDTH-1 -> STOP.
- STOP state, on en=1 (always returns to IDLE next cycle):
  - sdata=1 with buffer free (valid_o=0, or valid_o=1 and ready_i=1 this cycle): data_o<=shreg; valid_o=1 next cycle.
  - sdata=1 with buffer full (valid_o=1, ready_i=0): new word discarded; data_o and valid_o unchanged; overrun_o<=1.
  - sdata=0: word discarded; frame_err_o<=1. The low stop bit is not treated as a new start bit.
- Latency: valid_o rises one clk after the en-qualified stop sample.
- Handshake:
  - A transfer occurs on a cycle where valid_o=1 and ready_i=1.
  - valid_o falls next cycle unless a new word loads on the same cycle; in that case valid_o stays 1 with the new data.
  - data_o is stable while valid_o=1 and ready_i=0.
- Sticky flags:
  - clr_i=1 clears both flags next cycle.
  - If a set event and clr_i occur on the same cycle, set wins.
- busy_o is combinational from the state register: 1 in DATA and STOP.
- Reset mid-frame returns to IDLE, discards the partial word, drops valid_o, and clears the flags.
- Back-to-back frames: a start bit on the en sample immediately after the stop bit is accepted.

Test Plan:
- MSB-first, en every cycle, bits 0,1,0,1,0,0,1,0,1,1 -> data_o=0xA5, valid_o=1 exactly one clk after the stop sample, busy_o=0 afterwards.
- LSB-first, en every 4th cycle, send 0x3C (data bits 0,0,1,1,1,1,0,0) -> data_o=0x3C. Toggling msb_first mid-frame has no effect.
- ready_i=0; send 0x11 then 0x22 -> data_o stays 0x11, overrun_o=1. Assert clr_i, then ready_i -> valid_o=0 and overrun_o=0 next cycle.
- ready_i=1 on the same cycle the 0x22 stop bit is sampled while 0x11 is pending -> 0x11 consumed, data_o=0x22, valid_o remains 1, overrun_o=0.
- Stop bit sampled as 0 for 0x55 -> frame_err_o=1, valid_o unchanged. Next frame 0x0F still received correctly.
- nrst=0 after 4 data bits -> busy_o=0 and all outputs 0 next clk. A following full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/serial_deser.sv
// serial_deser: framed serial receiver (start bit, WIDTH data bits, stop bit).
// Rebuilds the parallel word in MSB-first or LSB-first order. The word is
// presented through a one-entry valid/ready buffer. Overrun and framing
// errors are reported as sticky flags.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | line idle, waiting for an en-qualified low (start) sample
// S_DATA | shifting in WIDTH data bits, one per en-qualified sample
// S_STOP | waiting for the stop sample; decides load/overrun/frame error
module serial_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             sdata,
    input  logic             msb_first,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             frame_err_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             xfer;
    logic             load;
    logic             set_ovr;
    logic             set_ferr;

    // State register and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, shift, output-buffer and sticky-flag logic.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        order_d  = order_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        load     = 1'b0;
        set_ovr  = 1'b0;
        set_ferr = 1'b0;
        xfer     = valid_q & ready_i;

        case (state_q)
            S_IDLE: begin
                if (en && !sdata) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    // Bit order is frozen for the whole frame.
                    order_d = msb_first;
                end
            end
            S_DATA: begin
                if (en) begin
                    if (order_q) begin
                        shreg_d = {shreg_q[WIDTH-2:0], sdata};
                    end else begin
                        shreg_d = {sdata, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (en) begin
                    // A low stop bit is never reinterpreted as a start bit.
                    state_d = S_IDLE;
                    if (sdata) begin
                        if (!valid_q || ready_i) begin
                            load = 1'b1;
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load on the same cycle as a transfer keeps valid high with new data.
        if (load) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        // Set has priority over clear.
        if (set_ovr) begin
            ovr_d = 1'b1;
        end else if (clr_i) begin
            ovr_d = 1'b0;
        end

        if (set_ferr) begin
            ferr_d = 1'b1;
        end else if (clr_i) begin
            ferr_d = 1'b0;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = ovr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: directed frames plus a frame-level reference model
// compared against the DUT every cycle, and literal expectations.
module tb_serial_deser;

    localparam int W = 8;

    logic         clk;
    logic         nrst;
    logic         en;
    logic         sdata;
    logic         msb_first;
    logic         ready_i;
    logic         clr_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic         overrun_o;
    logic         frame_err_o;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    serial_deser #(.WIDTH(W)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .sdata       (sdata),
        .msb_first   (msb_first),
        .ready_i     (ready_i),
        .clr_i       (clr_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame position (-1 idle, 0..W-1 data, W stop),
    // collected bits, and the word assembled by position arithmetic.
    int           m_pos;
    bit           m_order;
    bit           m_bits [W];
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_ovr;
    bit           m_ferr;
    bit           m_load, m_xfer, m_so, m_sf;
    logic [W-1:0] m_word;

    always @(posedge clk) begin
        if (!nrst) begin
            m_pos = -1; m_order = 0; m_data = '0;
            m_valid = 0; m_ovr = 0; m_ferr = 0;
        end else begin
            m_xfer = m_valid && ready_i;
            m_load = 0; m_so = 0; m_sf = 0;
            if (en) begin
                if (m_pos < 0) begin
                    if (!sdata) begin
                        m_pos = 0;
                        m_order = msb_first;
                    end
                end else if (m_pos < W) begin
                    m_bits[m_pos] = sdata;
                    m_pos++;
                end else begin
                    if (sdata) begin
                        if (!m_valid || ready_i) m_load = 1;
                        else m_so = 1;
                    end else begin
                        m_sf = 1;
                    end
                    m_pos = -1;
                end
            end
            if (m_load) begin
                m_word = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_order) m_word[W-1-i] = m_bits[i];
                    else         m_word[i]     = m_bits[i];
                end
                m_data  = m_word;
                m_valid = 1;
            end else if (m_xfer) begin
                m_valid = 0;
            end
            if (m_so) m_ovr = 1; else if (clr_i) m_ovr = 0;
            if (m_sf) m_ferr = 1; else if (clr_i) m_ferr = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            checks++;
            if (data_o !== m_data) begin
                errors++;
                $display("FAIL model_data t=%0t: got %0h expected %0h", $time, data_o, m_data);
            end
            checks++;
            if (valid_o !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t: got %0b expected %0b", $time, valid_o, m_valid);
            end
            checks++;
            if (busy_o !== (m_pos >= 0)) begin
                errors++;
                $display("FAIL model_busy t=%0t: got %0b expected %0b", $time, busy_o, (m_pos >= 0));
            end
            checks++;
            if (overrun_o !== m_ovr) begin
                errors++;
                $display("FAIL model_overrun t=%0t: got %0b expected %0b", $time, overrun_o, m_ovr);
            end
            checks++;
            if (frame_err_o !== m_ferr) begin
                errors++;
                $display("FAIL model_frame_err t=%0t: got %0b expected %0b", $time, frame_err_o, m_ferr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic b);
        @(negedge clk);
        en = e;
        sdata = b;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap - 1) cyc(1'b0, 1'b1);
        cyc(1'b1, b);
    endtask

    // Start bit plus data bits; stop bit is sent separately.
    task automatic send_bits(input logic [W-1:0] w, input logic msb, input int gap, input bit toggle);
        msb_first = msb;
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) begin
            if (toggle && i == W / 2) msb_first = ~msb_first;
            send_bit(msb ? w[W-1-i] : w[i], gap);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        en = 1'b0; sdata = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; sdata = 1'b1; msb_first = 1'b1;
        ready_i = 1'b0; clr_i = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        checking = 1;
        chk("reset_data", 32'(data_o), 32'h0);
        chk("reset_valid", 32'(valid_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_flags", {30'd0, overrun_o, frame_err_o}, 32'h0);

        // MSB-first 0xA5, en every cycle.
        send_bits(8'hA5, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        chk("a5_valid_before", 32'(valid_o), 32'h0);
        cyc(1'b0, 1'b1);
        chk("a5_data", 32'(data_o), 32'hA5);
        chk("a5_valid", 32'(valid_o), 32'h1);
        chk("a5_busy", 32'(busy_o), 32'h0);
        consume();
        chk("a5_consumed", 32'(valid_o), 32'h0);

        // LSB-first 0x3C, en every 4th cycle, msb_first toggled mid-frame.
        send_bits(8'h3C, 1'b0, 4, 1'b1);
        send_bit(1'b1, 4);
        cyc(1'b0, 1'b1);
        chk("3c_data", 32'(data_o), 32'h3C);
        consume();

        // Overrun: 0x11 pending, 0x22 dropped.
        msb_first = 1'b1;
        send_bits(8'h11, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        send_bits(8'h22, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        cyc(1'b0, 1'b1);
        chk("ovr_data", 32'(data_o), 32'h11);
        chk("ovr_flag", 32'(overrun_o), 32'h1);
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0;
        chk("ovr_cleared", 32'(overrun_o), 32'h0);
        chk("ovr_still_valid", 32'(valid_o), 32'h1);
        @(negedge clk); ready_i = 1'b1;
        @(negedge clk); ready_i = 1'b0;
        chk("ovr_drained", 32'(valid_o), 32'h0);

        // Simultaneous consume and load.
        send_bits(8'h11, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        send_bits(8'h22, 1'b1, 1, 1'b0);
        @(negedge clk); en = 1'b1; sdata = 1'b1; ready_i = 1'b1;
        @(negedge clk); en = 1'b0; ready_i = 1'b0;
        chk("swap_data", 32'(data_o), 32'h22);
        chk("swap_valid", 32'(valid_o), 32'h1);
        chk("swap_ovr", 32'(overrun_o), 32'h0);

        // Framing error on 0x55 while 0x22 is pending.
        send_bits(8'h55, 1'b1, 1, 1'b0);
        send_bit(1'b0, 1);
        cyc(1'b1, 1'b1);
        chk("ferr_flag", 32'(frame_err_o), 32'h1);
        chk("ferr_data", 32'(data_o), 32'h22);
        chk("ferr_valid", 32'(valid_o), 32'h1);
        chk("ferr_not_start", 32'(busy_o), 32'h0);
        consume();
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0;
        send_bits(8'h0F, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        cyc(1'b0, 1'b1);
        chk("0f_data", 32'(data_o), 32'h0F);
        chk("0f_ferr_clear", 32'(frame_err_o), 32'h0);

        // Reset after 4 data bits, 0x0F still pending.
        send_bit(1'b0, 1);
        repeat (4) send_bit(1'b1, 1);
        @(negedge clk); nrst = 1'b0; en = 1'b0; sdata = 1'b1;
        @(negedge clk); nrst = 1'b1;
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        send_bits(8'hC3, 1'b1, 1, 1'b0);
        send_bit(1'b1, 1);
        cyc(1'b0, 1'b1);
        chk("c3_data", 32'(data_o), 32'hC3);
        chk("c3_valid", 32'(valid_o), 32'h1);

        repeat (3) cyc(1'b0, 1'b1);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
